// File: rtl/output_port_arbiter_if.sv
// Bundle between the four input-port demultiplexers, the output port arbiter
// and the outgoing link.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both high in the cycle before it. Ready never depends on state that the
// valid side can only know after the edge, and valid, once high, holds its
// data until the transfer. On the input side, in_readyN is the grant, so
// in_flitN is taken in any cycle where in_validN & in_readyN. On the link
// side, out_flit is taken in any cycle where out_valid & out_ready.
interface output_port_arbiter_if #(
  parameter int W  = 34,
  parameter int PW = 2
);
  logic [W-1:0] in_flit1;
  logic [W-1:0] in_flit2;
  logic [W-1:0] in_flit3;
  logic [W-1:0] in_flit4;
  logic         in_valid1;
  logic         in_valid2;
  logic         in_valid3;
  logic         in_valid4;
  logic         in_ready1;
  logic         in_ready2;
  logic         in_ready3;
  logic         in_ready4;
  logic [W-1:0] out_flit;
  logic         out_valid;
  logic         out_ready;
  logic         port_block;
  logic [PW:0]  occupancy;
  logic [1:0]   dbg_rr_ptr;

  // Arbiter side: consumes flits from the input ports, produces the link.
  modport slave (
    input  in_flit1, in_flit2, in_flit3, in_flit4,
    input  in_valid1, in_valid2, in_valid3, in_valid4,
    output in_ready1, in_ready2, in_ready3, in_ready4,
    output out_flit, out_valid,
    input  out_ready,
    output port_block, occupancy, dbg_rr_ptr
  );

  // Environment side: input ports and link.
  modport master (
    output in_flit1, in_flit2, in_flit3, in_flit4,
    output in_valid1, in_valid2, in_valid3, in_valid4,
    input  in_ready1, in_ready2, in_ready3, in_ready4,
    input  out_flit, out_valid,
    output out_ready,
    input  port_block, occupancy, dbg_rr_ptr
  );
endinterface

// File: rtl/output_port_arbiter.sv
// Output stage of a router port: round-robin pick of one flit per cycle from
// the four input ports, queued in a small FIFO and driven onto the link.
// The round-robin pointer is exported as dbg_rr_ptr for observation.
module output_port_arbiter #(
  parameter int MODIFIED_FLIT_SIZE = 34,
  parameter int FIFO_DEPTH         = 4,
  parameter int PTR_WIDTH          = 2
) (
  input logic                  clk,
  input logic                  reset,
  output_port_arbiter_if.slave bus
);
  localparam int W  = MODIFIED_FLIT_SIZE;
  localparam int CW = PTR_WIDTH + 1;

  logic [W-1:0]         mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]        count;
  logic [1:0]           rr_ptr;

  logic [3:0]   valid_vec;
  logic [W-1:0] flit_arr [4];
  logic [3:0]   grant_vec;
  logic [1:0]   grant_idx;
  logic         push;
  logic         pop;
  logic         can_accept;

  assign valid_vec   = {bus.in_valid4, bus.in_valid3, bus.in_valid2, bus.in_valid1};
  assign flit_arr[0] = bus.in_flit1;
  assign flit_arr[1] = bus.in_flit2;
  assign flit_arr[2] = bus.in_flit3;
  assign flit_arr[3] = bus.in_flit4;

  assign bus.out_valid  = (count != '0);
  assign bus.out_flit   = (count != '0) ? mem[rd_ptr] : '0;
  assign bus.port_block = (count == CW'(FIFO_DEPTH));
  assign bus.occupancy  = count;
  assign bus.dbg_rr_ptr = rr_ptr;

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign pop        = bus.out_valid & bus.out_ready;
  assign can_accept = (count < CW'(FIFO_DEPTH)) | pop;

  // Round-robin scan from rr_ptr; grant suppressed when full or in reset.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found     = 1'b0;
    idx       = '0;
    grant_idx = '0;
    grant_vec = '0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && valid_vec[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    if (found && can_accept && !reset) grant_vec[grant_idx] = 1'b1;
  end

  assign push = |grant_vec;

  assign bus.in_ready1 = grant_vec[0];
  assign bus.in_ready2 = grant_vec[1];
  assign bus.in_ready3 = grant_vec[2];
  assign bus.in_ready4 = grant_vec[3];

  // Pointers, count and round-robin state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_WIDTH'(1);
        rr_ptr <= grant_idx + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // FIFO storage; contents are meaningful only between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= flit_arr[grant_idx];
  end
endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_output_port_arbiter;
  localparam int W = 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0]   v_in = '0;
  logic         ordy = 1'b0;
  logic [W-1:0] f [4];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state.
  logic [W-1:0] exp_q[$];
  int           m_rr = 0;

  output_port_arbiter_if #(.W(W), .PW(2)) bus ();

  output_port_arbiter #(
    .MODIFIED_FLIT_SIZE(W), .FIFO_DEPTH(4), .PTR_WIDTH(2)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  assign bus.in_flit1  = f[0];
  assign bus.in_flit2  = f[1];
  assign bus.in_flit3  = f[2];
  assign bus.in_flit4  = f[3];
  assign bus.in_valid1 = v_in[0];
  assign bus.in_valid2 = v_in[1];
  assign bus.in_valid3 = v_in[2];
  assign bus.in_valid4 = v_in[3];
  assign bus.out_ready = ordy;

  // Clock / reset block.
  always #5 clk = ~clk;

  function automatic logic [3:0] rdy_vec();
    return {bus.in_ready4, bus.in_ready3, bus.in_ready2, bus.in_ready1};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock cycle: check all outputs against the model with the current
  // inputs, advance the model as the rising edge will, then move to the
  // next falling edge where new inputs are applied.
  task automatic step();
    logic [3:0]   e_rdy;
    logic [W-1:0] e_flit;
    bit           can;
    bit           found;
    int           gp;
    #1;
    e_rdy  = '0;
    found  = 0;
    gp     = 0;
    e_flit = (exp_q.size() != 0) ? exp_q[0] : '0;
    can    = (exp_q.size() < 4) || (exp_q.size() > 0 && ordy);
    if (!rst && can) begin
      for (int k = 0; k < 4; k++) begin
        if (!found && v_in[(m_rr + k) % 4]) begin
          found = 1;
          gp    = (m_rr + k) % 4;
        end
      end
      if (found) e_rdy[gp] = 1'b1;
    end
    chk("in_ready",   64'(rdy_vec()),          64'(e_rdy));
    chk("out_valid",  64'(bus.out_valid),      64'(exp_q.size() != 0));
    chk("out_flit",   64'(bus.out_flit),       64'(e_flit));
    chk("port_block", 64'(bus.port_block),     64'(exp_q.size() == 4));
    chk("occupancy",  64'(bus.occupancy),      64'(exp_q.size()));
    chk("rr_ptr",     64'(bus.dbg_rr_ptr),     64'(m_rr));
    if (rst) begin
      exp_q.delete();
      m_rr = 0;
    end else begin
      if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
      if (found) begin
        exp_q.push_back(f[gp]);
        m_rr = (gp + 1) % 4;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic o);
    rst  = r;
    v_in = v;
    ordy = o;
  endtask

  function automatic logic [W-1:0] rnd_flit();
    return {2'($urandom_range(0, 3)), 32'($urandom)};
  endfunction

  logic [W-1:0] sent [8];
  logic [W-1:0] fa, fb, fc;

  initial begin
    for (int p = 0; p < 4; p++) f[p] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // 1: reset then idle
    drive(1, 4'h0, 0); step();
    drive(0, 4'h0, 0); settle();
    chk("t1_out_valid", 64'(bus.out_valid), 64'(0));
    chk("t1_out_flit",  64'(bus.out_flit),  64'(0));
    chk("t1_occupancy", 64'(bus.occupancy), 64'(0));
    step(); step();

    // 2: single flit on port 2
    f[1] = 34'h1_0000_00AB;
    drive(0, 4'b0010, 1); settle();
    chk("t2_grant", 64'(rdy_vec()), 64'(4'b0010));
    step();
    drive(0, 4'b0000, 1); settle();
    chk("t2_out_valid", 64'(bus.out_valid), 64'(1));
    chk("t2_out_flit",  64'(bus.out_flit),  64'(34'h1_0000_00AB));
    step(); settle();
    chk("t2_occupancy", 64'(bus.occupancy), 64'(0));

    // 3: all ports valid, grant order 1,2,3,4,1,2,3,4
    drive(1, 4'h0, 1); step();
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < 4; p++) f[p] = rnd_flit();
      drive(0, 4'hf, 1); settle();
      chk("t3_grant", 64'(rdy_vec()), 64'(4'b0001 << (i % 4)));
      if (i > 0) chk("t3_order", 64'(bus.out_flit), 64'(sent[i-1]));
      sent[i] = f[i % 4];
      step();
    end
    drive(0, 4'h0, 1); settle();
    chk("t3_order", 64'(bus.out_flit), 64'(sent[7]));
    step(); step();

    // 4: back-pressure on port 3
    for (int i = 0; i < 5; i++) begin
      f[2] = rnd_flit();
      drive(0, 4'b0100, 0); step();
    end
    f[2] = rnd_flit();
    drive(0, 4'b0100, 0); settle();
    chk("t4_blocked",   64'(rdy_vec()),      64'(0));
    chk("t4_port_blk",  64'(bus.port_block), 64'(1));
    chk("t4_occupancy", 64'(bus.occupancy),  64'(4));
    drive(0, 4'b0100, 1); settle();
    chk("t4_full_push", 64'(rdy_vec()), 64'(4'b0100));
    step(); settle();
    chk("t4_occ_hold", 64'(bus.occupancy), 64'(4));
    drive(0, 4'h0, 1);
    repeat (5) step();

    // 5: A, B, C across a pointer wrap
    fa = 34'h2_AAAA_0001; fb = 34'h3_BBBB_0002; fc = 34'h0_CCCC_0003;
    f[0] = fa; drive(0, 4'b0001, 0); step();
    f[0] = fb; drive(0, 4'b0001, 0); step();
    f[0] = fc; drive(0, 4'b0001, 0); step();
    drive(0, 4'h0, 1); settle();
    chk("t5_a", 64'(bus.out_flit), 64'(fa)); step(); settle();
    chk("t5_b", 64'(bus.out_flit), 64'(fb)); step(); settle();
    chk("t5_c", 64'(bus.out_flit), 64'(fc)); step(); settle();
    chk("t5_empty", 64'(bus.out_valid), 64'(0));

    // 6: reset with occupancy 3 and a grant pending
    for (int i = 0; i < 3; i++) begin
      f[1] = rnd_flit(); drive(0, 4'b0010, 0); step();
    end
    settle();
    chk("t6_occ3", 64'(bus.occupancy), 64'(3));
    drive(1, 4'hf, 0); settle();
    chk("t6_no_grant", 64'(rdy_vec()), 64'(0));
    step();
    drive(0, 4'hf, 0); settle();
    chk("t6_out_valid", 64'(bus.out_valid),  64'(0));
    chk("t6_occupancy", 64'(bus.occupancy),  64'(0));
    chk("t6_rr_ptr",    64'(bus.dbg_rr_ptr), 64'(0));
    chk("t6_port1",     64'(rdy_vec()),      64'(4'b0001));
    step();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 4; p++) f[p] = rnd_flit();
      drive(($urandom_range(0, 59) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) != 0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
